// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// MUL is radix-2 shift-add, DIV is restoring; both take 32 iterations plus a sign-fix cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e      r_state, w_state_d;
  logic [4:0]  r_cnt, w_cnt_d;
  logic [63:0] r_acc, w_acc_d;
  logic [31:0] r_opb, w_opb_d;
  logic        r_is_div, w_is_div_d;
  logic        r_neg_q, w_neg_q_d;
  logic        r_neg_r, w_neg_r_d;
  logic [31:0] r_hi, w_hi_d;
  logic [31:0] r_lo, w_lo_d;
  logic        r_done, w_done_d;
  logic        r_busy;

  logic        w_signed;
  logic [31:0] w_mag_a, w_mag_b;
  logic        w_neg_q, w_neg_r;
  logic [32:0] w_mul_sum;
  logic        w_div_ge;
  logic [31:0] w_div_sub;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;

  // Ops 000 and 010 are the signed variants.
  assign w_signed = ~op[0];
  assign w_mag_a  = (w_signed & a[31]) ? (~a + 32'd1) : a;
  assign w_mag_b  = (w_signed & b[31]) ? (~b + 32'd1) : b;
  // A zero divisor leaves the all-ones quotient unnegated.
  assign w_neg_q  = w_signed & (a[31] ^ b[31]) & (|b);
  assign w_neg_r  = w_signed & a[31];

  // Multiplier sits in acc[31:0] and shifts out LSB-first; partial product grows in acc[63:32].
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);

  // Dividend shifts out of acc[31:0] MSB-first into the remainder held in acc[63:32].
  assign w_div_ge  = r_acc[63:31] >= {1'b0, r_opb};
  assign w_div_sub = r_acc[62:31] - r_opb;

  assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_acc_d    = r_acc;
    w_opb_d    = r_opb;
    w_is_div_d = r_is_div;
    w_neg_q_d  = r_neg_q;
    w_neg_r_d  = r_neg_r;
    w_hi_d     = r_hi;
    w_lo_d     = r_lo;
    w_done_d   = 1'b0;

    if (flush) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            unique case (op)
              3'b000, 3'b001: begin
                w_state_d  = StMul;
                w_acc_d    = {32'd0, w_mag_b};
                w_opb_d    = w_mag_a;
                w_is_div_d = 1'b0;
                w_neg_q_d  = w_neg_q;
                w_neg_r_d  = w_neg_r;
                w_cnt_d    = 5'd31;
              end
              3'b010, 3'b011: begin
                w_state_d  = StDiv;
                w_acc_d    = {32'd0, w_mag_a};
                w_opb_d    = w_mag_b;
                w_is_div_d = 1'b1;
                w_neg_q_d  = w_neg_q;
                w_neg_r_d  = w_neg_r;
                w_cnt_d    = 5'd31;
              end
              3'b100:  w_hi_d = a;
              3'b101:  w_lo_d = a;
              default: ;
            endcase
          end
        end
        StMul: begin
          w_acc_d = {w_mul_sum, r_acc[31:1]};
          w_cnt_d = r_cnt - 5'd1;
          if (r_cnt == 5'd0) w_state_d = StFix;
        end
        StDiv: begin
          w_acc_d = w_div_ge ? {w_div_sub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
          w_cnt_d = r_cnt - 5'd1;
          if (r_cnt == 5'd0) w_state_d = StFix;
        end
        StFix: begin
          if (r_is_div) begin
            w_hi_d = w_rem;
            w_lo_d = w_quo;
          end else begin
            w_hi_d = w_prod[63:32];
            w_lo_d = w_prod[31:0];
          end
          w_cnt_d   = 5'd0;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= 5'd0;
      r_acc    <= 64'd0;
      r_opb    <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_acc    <= w_acc_d;
      r_opb    <= w_opb_d;
      r_is_div <= w_is_div_d;
      r_neg_q  <= w_neg_q_d;
      r_neg_r  <= w_neg_r_d;
      r_hi     <= w_hi_d;
      r_lo     <= w_lo_d;
      r_done   <= w_done_d;
      r_busy   <= (w_state_d != StIdle);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO pairs are queued at issue and
// compared against the outputs when the done pulse arrives.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [63:0] sb[$];

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge (cycle 0). Returns #1 after the edge that starts cycle 34.
  // With noise set, start is re-asserted with junk during cycles 5-20.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp, input bit noise);
    logic [63:0] held;
    logic [63:0] got;
    int          n;
    bit          busy_ok;
    bit          hold_ok;
    sb.push_back(exp);
    held  = {hi, lo};
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    n       = 1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      start = noise && n >= 5 && n <= 20;
      op    = 3'($urandom_range(0, 5));
      a     = $urandom;
      b     = $urandom;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if ({hi, lo} !== held) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_busy_window"}, 64'(busy_ok), 64'd1);
    check({tag, "_hilo_hold"}, 64'(hold_ok), 64'd1);
    check({tag, "_done_cycle"}, 64'(n), 64'd34);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      got = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(got[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(got[31:0]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    flush = 1'b0;
    #3;
    check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    check("done_single", 64'(done), 64'd1);
    // Back-to-back issue in the done cycle
    run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    @(posedge clk);
    #1;
    check("done_drop", {62'd0, busy, done}, 64'd0);

    run_op("divu_zero", 3'b011, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1'b0);
    run_op("div_zero_neg", 3'b010, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF, 1'b0);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run_op("div_rem_sign", 3'b010, 32'd17, 32'hFFFF_FFFB, 64'h0000_0002_FFFF_FFFD, 1'b0);
    run_op("mult_negneg", 3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006, 1'b0);
    run_op("divu_noise", 3'b011, 32'd1000, 32'd7, 64'h0000_0006_0000_008E, 1'b1);

    // MTHI / MTLO
    start = 1'b1;
    op    = 3'b100;
    a     = 32'h1234_5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    check("mthi_lo_kept", 64'(lo), 64'h0000_008E);
    check("mthi_flags", {62'd0, busy, done}, 64'd0);
    start = 1'b1;
    op    = 3'b101;
    a     = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
    check("mtlo_flags", {62'd0, busy, done}, 64'd0);

    // Flush in IDLE suppresses an MTLO
    start = 1'b1;
    flush = 1'b1;
    op    = 3'b101;
    a     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("idle_flush_lo", 64'(lo), 64'hCAFE_F00D);

    // Reserved op is ignored
    start = 1'b1;
    op    = 3'b110;
    a     = 32'h5555_5555;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("reserved_ignored", {30'd0, busy, done, hi}, 64'h1234_5678);

    // Flush a MULT in cycle 10
    start = 1'b1;
    op    = 3'b000;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'h1234_5678);
    check("flush_lo", 64'(lo), 64'hCAFE_F00D);
    check("flush_done", 64'(done), 64'd0);
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    check("flush_no_late_done", {62'd0, busy, done}, 64'd0);

    // Asynchronous reset mid-MULT in cycle 15
    start = 1'b1;
    op    = 3'b000;
    a     = 32'd5;
    b     = 32'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", {62'd0, busy, done}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    #2;
    rst_n = 1'b1;
    run_op("post_rst_multu", 3'b001, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
